uart_rx_fifo: RTL and testbench

//   Receive-side byte buffer directly downstream of uart_rx. Captures each byte announced by
//   the receiver's one-cycle rcv strobe and holds it in a small show-ahead FIFO. Bytes are

---
 rtl/uart_rx_fifo.sv | 99 +++++++++
 tb/tb_uart_rx_fifo.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO between uart_rx and its consumer, with a sticky overflow flag.
// Optional drop counter port enabled by defining UART_RX_FIFO_DROP_CNT_EN.
module uart_rx_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rcv,
  input  logic [DATA_W-1:0]     din,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  overflow,
`ifdef UART_RX_FIFO_DROP_CNT_EN
  output logic [7:0]            drop_cnt,
`endif
  input  logic                  ovf_clr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DEPTH_LOG2:0] r_wrPtr;
  logic [DEPTH_LOG2:0] r_rdPtr;
  logic [DEPTH_LOG2:0] r_level;
  logic                r_full;
  logic                r_valid;
  logic                r_overflow;

  logic                w_pop;
  logic                w_push;
  logic                w_drop;
  logic [DEPTH_LOG2:0] w_wrNext;
  logic [DEPTH_LOG2:0] w_rdNext;
  logic [DEPTH_LOG2:0] w_levelNext;

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign w_pop       = r_valid & out_ready;
  assign w_push      = rcv & (~r_full | w_pop);
  assign w_drop      = rcv & ~w_push;
  assign w_wrNext    = r_wrPtr + {{DEPTH_LOG2{1'b0}}, w_push};
  assign w_rdNext    = r_rdPtr + {{DEPTH_LOG2{1'b0}}, w_pop};
  assign w_levelNext = w_wrNext - w_rdNext;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_level    <= '0;
      r_full     <= 1'b0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_wrPtr <= w_wrNext;
      r_rdPtr <= w_rdNext;
      r_level <= w_levelNext;
      r_full  <= (w_levelNext == FULL_LEVEL);
      r_valid <= (w_levelNext != '0);
      if (w_drop)
        r_overflow <= 1'b1;
      else if (ovf_clr)
        r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wrPtr[DEPTH_LOG2-1:0]] <= din;
  end

`ifdef UART_RX_FIFO_DROP_CNT_EN
  logic [7:0] r_dropCnt;

  // A drop coinciding with a clear restarts the count at one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r_dropCnt <= '0;
    else if (w_drop && ovf_clr)
      r_dropCnt <= 8'd1;
    else if (w_drop && r_dropCnt != 8'hFF)
      r_dropCnt <= r_dropCnt + 8'd1;
    else if (ovf_clr)
      r_dropCnt <= '0;
  end

  assign drop_cnt = r_dropCnt;
`endif

  assign out_valid = r_valid;
  assign out_data  = r_valid ? r_mem[r_rdPtr[DEPTH_LOG2-1:0]] : '0;
  assign level     = r_level;
  assign full      = r_full;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: vector table for single-step behaviour, hand sequences
// for fill/drain, overflow, full push+pop, pointer wrap and asynchronous reset.
module tb_uart_rx_fifo;

  logic       clk;
  logic       rstn;
  logic       rcv;
  logic [7:0] din;
  logic       outValid;
  logic [7:0] outData;
  logic       outReady;
  logic [4:0] level;
  logic       full;
  logic       overflow;
  logic       ovfClr;
`ifdef UART_RX_FIFO_DROP_CNT_EN
  logic [7:0] dropCnt;
`endif

  int nChecks = 0;
  int nFails  = 0;

  uart_rx_fifo #(.DATA_W(8), .DEPTH_LOG2(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .rcv       (rcv),
    .din       (din),
    .out_valid (outValid),
    .out_data  (outData),
    .out_ready (outReady),
    .level     (level),
    .full      (full),
    .overflow  (overflow),
`ifdef UART_RX_FIFO_DROP_CNT_EN
    .drop_cnt  (dropCnt),
`endif
    .ovf_clr   (ovfClr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rcv;
    logic [7:0] din;
    logic       ready;
    logic       clr;
    logic       expValid;
    logic [7:0] expData;
    logic [4:0] expLevel;
    logic       expFull;
    logic       expOvf;
  } vec_t;

  vec_t vecs [9];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic v, input logic [7:0] d,
                          input logic [4:0] l, input logic f, input logic o);
    checkOutput({tag, ".out_valid"}, 32'(outValid), 32'(v));
    checkOutput({tag, ".out_data"},  32'(outData),  32'(d));
    checkOutput({tag, ".level"},     32'(level),    32'(l));
    checkOutput({tag, ".full"},      32'(full),     32'(f));
    checkOutput({tag, ".overflow"},  32'(overflow), 32'(o));
  endtask

  // Drive one cycle's inputs at the falling edge; outputs are settled 1 time unit after the rise.
  task automatic applyStimulus(input logic r, input logic [7:0] d, input logic rdy, input logic c);
    @(negedge clk);
    rcv      = r;
    din      = d;
    outReady = rdy;
    ovfClr   = c;
    @(posedge clk);
    #1;
    rcv      = 1'b0;
    outReady = 1'b0;
    ovfClr   = 1'b0;
  endtask

  initial begin
    logic [7:0] model[$];
    int pushed;
    int popped;
    logic r;
    logic rdy;
    logic doPop;
    logic doPush;

    rstn = 1'b0; rcv = 1'b0; din = '0; outReady = 1'b0; ovfClr = 1'b0;

    //               rcv   din    rdy   clr   valid data   lvl  full ovf
    vecs[0] = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b1, 8'h41, 5'd1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'h42, 1'b1, 1'b0, 1'b1, 8'h42, 5'd1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'h7E, 1'b0, 1'b0, 1'b1, 8'h7E, 5'd1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 8'h7F, 1'b0, 1'b0, 1'b1, 8'h7E, 5'd2, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h7F, 5'd1, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h7F, 5'd1, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};

    #23;
    checkAll("reset", 1'b0, 8'h00, 5'd0, 1'b0, 1'b0);
`ifdef UART_RX_FIFO_DROP_CNT_EN
    checkOutput("reset.drop_cnt", 32'(dropCnt), 32'd0);
`endif
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].rcv, vecs[i].din, vecs[i].ready, vecs[i].clr);
      checkAll($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expData,
               vecs[i].expLevel, vecs[i].expFull, vecs[i].expOvf);
    end

    // Fill to capacity, then drain and confirm order.
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(i + 1), 1'b0, 1'b0);
    checkAll("fill16", 1'b1, 8'h01, 5'd16, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("drain%0d.data", i), 32'(outData), 32'(i + 1));
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checkAll("drained", 1'b0, 8'h00, 5'd0, 1'b0, 1'b0);

    // Overflow on a full FIFO, then clear.
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(i + 1), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
    checkAll("drop", 1'b1, 8'h01, 5'd16, 1'b1, 1'b1);
`ifdef UART_RX_FIFO_DROP_CNT_EN
    checkOutput("drop.drop_cnt", 32'(dropCnt), 32'd1);
`endif
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkAll("ovfclr", 1'b1, 8'h01, 5'd16, 1'b1, 1'b0);
`ifdef UART_RX_FIFO_DROP_CNT_EN
    checkOutput("ovfclr.drop_cnt", 32'(dropCnt), 32'd0);
`endif

    // Push and pop together while full: the freed slot takes 0x55.
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
    checkAll("fullpp", 1'b1, 8'h02, 5'd16, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("ppdrain%0d.data", i), 32'(outData), (i == 15) ? 32'h55 : 32'(i + 2));
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checkAll("ppdrained", 1'b0, 8'h00, 5'd0, 1'b0, 1'b0);

    // Interleaved traffic with random ready against a queue model.
    pushed = 0;
    popped = 0;
    for (int cyc = 0; cyc < 400 && popped < 20; cyc++) begin
      r      = (pushed < 20) && ($urandom_range(0, 3) != 0);
      rdy    = 1'($urandom_range(0, 1));
      doPop  = (model.size() > 0) && rdy;
      doPush = r && ((model.size() < 16) || doPop);
      applyStimulus(r, 8'(8'h80 + pushed), rdy, 1'b0);
      if (doPop) begin
        void'(model.pop_front());
        popped++;
      end
      if (doPush) begin
        model.push_back(8'(8'h80 + pushed));
        pushed++;
      end
      checkOutput("wrap.level", 32'(level), 32'(model.size()));
      checkOutput("wrap.out_valid", 32'(outValid), 32'(model.size() > 0));
      if (model.size() > 0)
        checkOutput("wrap.out_data", 32'(outData), 32'(model[0]));
    end
    checkOutput("wrap.popped", 32'(popped), 32'd20);

    // Asynchronous reset with five entries stored.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    checkAll("pre_rst", 1'b1, 8'hC0, 5'd5, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    rcv  = 1'b1;
    din  = 8'hEE;
    #1;
    checkAll("async_rst", 1'b0, 8'h00, 5'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkAll("rcv_in_rst", 1'b0, 8'h00, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    rcv  = 1'b0;
    rstn = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkAll("post_rst", 1'b0, 8'h00, 5'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b0);
    checkAll("post_rst_push", 1'b1, 8'h99, 5'd1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
